// File: rtl/bram_ctrl_pkg.sv
// Shared types and defaults for the BRAM read/write controllers.
// The read controller uses LEER in the middle state position.
package bram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ESCRIBIR = 2'b01,
    FIN      = 2'b10
  } state_t;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 8;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for an already-synchronous level input.
// Emits a one-cycle pulse on each 0->1 transition.
module btn_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic r_btn_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_btn_q <= 1'b0;
    else          r_btn_q <= i_btn;
  end

  assign o_rise = i_btn & ~r_btn_q;

endmodule

// File: rtl/bram_write_controller.sv
// Writes one word into BRAM port A per button press, tracking fill count and full.
// A press runs IDLE -> ESCRIBIR -> FIN; the address advances in FIN.
module bram_write_controller
  import bram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W,
  parameter int unsigned WRAP   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t            r_state, w_state_nxt;
  logic              r_wea, w_wea_nxt;
  logic [ADDR_W-1:0] r_addra, w_addra_nxt;
  logic [DATA_W-1:0] r_dina, w_dina_nxt;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic              r_done, w_done_nxt;
  logic              w_rise;
  logic              w_full;

  btn_edge_detect u_edge (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_btn   (btn),
    .o_rise  (w_rise)
  );

  assign w_full = (r_count == DEPTH_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wea   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wea   <= w_wea_nxt;
      r_addra <= w_addra_nxt;
      r_dina  <= w_dina_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wea_nxt   = 1'b0;
    w_addra_nxt = r_addra;
    w_dina_nxt  = r_dina;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        // clr wins over a coincident press; that press is lost, not deferred
        if (clr) begin
          w_addra_nxt = '0;
          w_count_nxt = '0;
        end else if (w_rise && ((WRAP != 0) || !w_full)) begin
          w_dina_nxt  = din;
          w_wea_nxt   = 1'b1;
          w_state_nxt = ESCRIBIR;
        end
      end
      ESCRIBIR: begin
        w_state_nxt = FIN;
      end
      FIN: begin
        w_addra_nxt = r_addra + ADDR_W'(1);
        if (r_count < DEPTH_C) w_count_nxt = r_count + (ADDR_W + 1)'(1);
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign wea   = r_wea;
  assign addra = r_addra;
  assign dina  = r_dina;
  assign count = r_count;
  assign full  = w_full;
  assign busy  = (r_state != IDLE);
  assign done  = r_done;

endmodule

// File: tb/tb_bram_write_controller.sv
// Bench for bram_write_controller: a wrapping and a non-wrapping instance share
// stimulus and are compared every cycle against a timeline model of each press.
module tb_bram_write_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] din = '0;

  logic       wea1, full1, busy1, done1;
  logic [3:0] addra1;
  logic [7:0] dina1;
  logic [4:0] count1;
  logic       wea0, full0, busy0, done0;
  logic [3:0] addra0;
  logic [7:0] dina0;
  logic [4:0] count0;

  int tests = 0;
  int fails = 0;
  int n_wea1 = 0;

  always #5 clk = ~clk;

  bram_write_controller #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .btn(btn), .clr(clr), .din(din),
    .wea(wea1), .addra(addra1), .dina(dina1), .count(count1),
    .full(full1), .busy(busy1), .done(done1)
  );

  bram_write_controller #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .WRAP(0)) u_nowrap (
    .clk(clk), .reset(reset), .btn(btn), .clr(clr), .din(din),
    .wea(wea0), .addra(addra0), .dina(dina0), .count(count0),
    .full(full0), .busy(busy0), .done(done0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: index 0 = WRAP=1 instance, index 1 = WRAP=0 instance.
  // m_left counts cycles still to go in an accepted press (2 after the write strobe).
  int   m_left [2];
  int   m_addr [2];
  int   m_count[2];
  logic m_wea  [2];
  logic m_done [2];
  logic [7:0] m_dina[2];
  logic m_btn_prev;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_btn_prev <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_left[i] <= 0; m_addr[i] <= 0; m_count[i] <= 0;
        m_wea[i] <= 1'b0; m_done[i] <= 1'b0; m_dina[i] <= '0;
      end
    end else begin
      m_btn_prev <= btn;
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 1'b0;
        m_wea[i]  <= 1'b0;
        if (m_left[i] == 2) begin
          m_left[i] <= 1;
        end else if (m_left[i] == 1) begin
          m_addr[i]  <= (m_addr[i] + 1) % 16;
          m_count[i] <= (m_count[i] < 16) ? m_count[i] + 1 : 16;
          m_done[i]  <= 1'b1;
          m_left[i]  <= 0;
        end else if (clr) begin
          m_addr[i]  <= 0;
          m_count[i] <= 0;
        end else if (btn && !m_btn_prev && (i == 0 || m_count[i] < 16)) begin
          m_wea[i]  <= 1'b1;
          m_dina[i] <= din;
          m_left[i] <= 2;
        end
      end
    end
  end

  function automatic logic [20:0] exp_vec(input int i);
    return {m_wea[i], 4'(m_addr[i]), m_dina[i], 5'(m_count[i]),
            m_count[i] == 16, m_left[i] != 0, m_done[i]};
  endfunction

  always @(negedge clk) begin
    check("cycle_wrap",   {wea1, addra1, dina1, count1, full1, busy1, done1}, 32'(exp_vec(0)));
    check("cycle_nowrap", {wea0, addra0, dina0, count0, full0, busy0, done0}, 32'(exp_vec(1)));
    if (reset && wea1) n_wea1 <= n_wea1 + 1;
    if ((wea1 && done1) || (wea0 && done0)) begin
      tests++; fails++;
      $display("FAIL wea_done_overlap: wea1=%0b done1=%0b wea0=%0b done0=%0b", wea1, done1, wea0, done0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0; btn = 1'b0; clr = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  task automatic press(input logic [7:0] d);
    btn = 1'b1; din = d;
    step();
    btn = 1'b0;
    repeat (3) step();
  endtask

  int n0;

  initial begin
    // Single press after reset
    do_reset();
    check("rst_addra", addra1, 0);
    check("rst_count", count1, 0);
    check("rst_wea", wea1, 0);
    btn = 1'b1; din = 8'hA5;
    step();
    check("p1_wea", wea1, 1);
    check("p1_addra", addra1, 0);
    check("p1_dina", dina1, 8'hA5);
    step();
    check("p1_wea_low", wea1, 0);
    step();
    check("p1_addra_inc", addra1, 1);
    check("p1_count", count1, 1);
    check("p1_done", done1, 1);
    step();
    check("p1_done_low", done1, 0);
    btn = 1'b0;
    step();

    // Held button: exactly one write, then a fresh edge writes at address 1
    do_reset();
    n0 = n_wea1;
    btn = 1'b1; din = 8'h3C;
    repeat (20) step();
    btn = 1'b0;
    step();
    check("held_pulses", n_wea1 - n0, 1);
    check("held_count", count1, 1);
    btn = 1'b1; din = 8'h5A;
    step();
    check("held2_wea", wea1, 1);
    check("held2_addra", addra1, 1);
    btn = 1'b0;
    repeat (3) step();

    // Fill 16, then a 17th press on both policies
    do_reset();
    for (int k = 0; k < 16; k++) press(8'(k * 3 + 1));
    check("fill_addra", addra1, 0);
    check("fill_count", count1, 16);
    check("fill_full", full1, 1);
    check("fill_full_nw", full0, 1);
    btn = 1'b1; din = 8'h77;
    step();
    check("p17_wea", wea1, 1);
    check("p17_addra", addra1, 0);
    check("p17_wea_nw", wea0, 0);
    check("p17_busy_nw", busy0, 0);
    btn = 1'b0;
    repeat (3) step();
    check("p17_addra_after", addra1, 1);
    check("p17_count", count1, 16);
    check("p17_addra_nw", addra0, 0);
    check("p17_count_nw", count0, 16);

    // clr coinciding with a rise in IDLE
    do_reset();
    press(8'h11);
    n0 = n_wea1;
    clr = 1'b1; btn = 1'b1; din = 8'h22;
    step();
    clr = 1'b0;
    repeat (3) step();
    btn = 1'b0;
    step();
    check("clr_rise_pulses", n_wea1 - n0, 0);
    check("clr_rise_addra", addra1, 0);
    check("clr_rise_count", count1, 0);

    // clr during ESCRIBIR is ignored
    btn = 1'b1; din = 8'h33;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    btn = 1'b0;
    step();
    check("clr_busy_addra", addra1, 1);
    check("clr_busy_count", count1, 1);
    step();

    // Asynchronous reset in the middle of a write
    press(8'h44);
    btn = 1'b1; din = 8'h55;
    step();
    check("mid_wea_pre", wea1, 1);
    #1 reset = 1'b0;
    #1;
    check("mid_wea", wea1, 0);
    check("mid_addra", addra1, 0);
    check("mid_count", count1, 0);
    check("mid_done", done1, 0);
    btn = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    step();
    check("post_busy", busy1, 0);
    btn = 1'b1; din = 8'h66;
    step();
    check("post_wea", wea1, 1);
    check("post_addra", addra1, 0);
    btn = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bram_write_controller.md
Name: bram_write_controller

Overview:
- Write-side counterpart of the BRAM read controller. It fills a single-port BRAM one word per button press.
- Each rising edge of btn captures din, issues a one-cycle write strobe at the current address, then advances the address.
- It sits between the user-input path (btn, din) and BRAM port A (wea, addra, dina).
- It tracks a fill count and a full flag, so the read side knows how many words are valid.

Parameters:
- ADDR_W, 4, address width of the BRAM port.
- DATA_W, 8, data word width.
- DEPTH, 16, number of words; must equal 2**ADDR_W.
- WRAP, 1, full-buffer policy. 1 = keep writing and wrap the address; 0 = ignore presses while full.

Ports:
- clk  in  1  system clock; every register is on its rising edge.
- reset  in  1  asynchronous, active-low reset. Asserted when 0.
- btn  in  1  write request, level input; only its rising edge counts. It must already be synchronous to clk.
- clr  in  1  synchronous clear of address and count; honoured only in IDLE.
- din  in  DATA_W  data to write, sampled on the accepted btn edge.
- wea  out  1  BRAM write enable.
- addra  out  ADDR_W  BRAM address.
- dina  out  DATA_W  BRAM write data.
- count  out  ADDR_W+1  number of words written; saturates at DEPTH.
- full  out  1  high when count==DEPTH.
- busy  out  1  high when state!=IDLE.
- done  out  1  one-cycle pulse when a write sequence completes.

Behaviour:
- Reset (reset==0, asynchronous):
  - wea=0, addra=0, dina=0, count=0, done=0, state=IDLE.
  - Internal btn_q=0.
  - wea drops immediately, even mid-write.
- Edge detect: btn_q<=btn every cycle in every state. rise = btn & ~btn_q.
- All outputs are registered. busy and full are decoded directly from registers.
- IDLE:
  - If clr: addra<=0, count<=0, stay IDLE. clr beats a simultaneous rise, and that rise is dropped.
  - Else if rise and (WRAP==1 or !full): dina<=din, wea<=1, go to ESCRIBIR.
  - Else stay IDLE; a rise while full with WRAP==0 is dropped.
- ESCRIBIR (exactly 1 cycle): wea<=0; addra and dina hold; go to FIN.
- FIN (exactly 1 cycle):
  - addra<=addra+1, modulo 2**ADDR_W, so 15 wraps to 0.
  - count<=count+1 if count<DEPTH, else hold.
  - done<=1; go to IDLE.
- done is high for exactly the first IDLE cycle after FIN, then returns to 0.
- Timing: rise sampled at edge N gives:
  - N+1: wea=1 and dina=din(N), with the pre-increment address. The BRAM writes at edge N+2.
  - N+3: addra incremented and done=1.
- At most one write per 3 cycles. btn held high produces exactly one write.
- A rise seen while in ESCRIBIR or FIN is dropped; it is neither queued nor re-detected.
- clr outside IDLE is ignored.
- Invariants:
  - wea is high for exactly one cycle per accepted press.
  - wea and done are never high together.
  - addra is stable while wea=1.
  - count never exceeds DEPTH.
- State encoding: IDLE=2'b00, ESCRIBIR=2'b01, FIN=2'b10. 2'b11 is illegal; its default branch recovers to IDLE with wea=0.

Decomposition:
- Package bram_ctrl_pkg holds:
  - the state typedef state_t with values IDLE/ESCRIBIR/FIN (the reader uses LEER in place of ESCRIBIR);
  - default ADDR_W/DATA_W constants shared with the read controller.
- One sub-module: btn_edge_detect (registers btn, outputs the one-cycle rise pulse, async active-low reset). It is reusable by the read controller.

Test Plan:
- Reset then a single press, din=8'hA5: wea=1 for one cycle with addra=0 and dina=A5. Three cycles after the rise, addra=1, count=1, done pulses once.
- btn held high for 20 cycles: exactly one wea pulse and count=1. A second edge after btn drops gives a second write at addra=1.
- 16 presses with WRAP=1, then a 17th:
  - after 16: addra wraps 15 to 0, count=16, full=1;
  - 17th press writes at addra=0 and count stays 16.
- Same sequence with WRAP=0: the 17th press produces no wea, busy stays 0, addra=0, count=16.
- clr and a rise in the same IDLE cycle: no write, addra=0, count=0.
- clr asserted during ESCRIBIR is ignored: the sequence completes and addra increments.
- reset pulled to 0 while wea=1: wea, addra, count, and done go to 0 asynchronously. After release the FSM is in IDLE, and the next press writes at addra=0.
